ee357_subword_store_unit: RTL and testbench

- Store-side counterpart of the load path's sign/zero extension.
- Narrows a 32-bit register value to a byte, halfword or word and merges it into word-addressed memory.
- Sub-word stores use read-modify-write.
- Sits between the multicycle CPU control FSM (SB/SH/SW) and the single-port data memory.

---
 rtl/ee357_subword_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_ee357_subword_store_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ee357_subword_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : ee357_subword_store_unit
// Brief    : SB/SH/SW store path. Narrows register data and merges sub-words
//            into memory by read-modify-write; defining
//            EE357_STORE_BYTE_ENABLE_EN replaces the read with lane enables.
// Revision : 1.0  initial release
// ============================================================================
module ee357_subword_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef EE357_STORE_BYTE_ENABLE_EN
    ,
    output logic [3:0]        mem_be
`endif
);

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FIN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_misalign;

    // size 11 is reserved and folded into the misaligned case
    assign w_misalign = (size == 2'b11)
                      | ((size == C_SZ_HALF) & addr[0])
                      | ((size == C_SZ_WORD) & (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        misalign = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_misalign) begin
                        w_next = S_ERR;
`ifdef EE357_STORE_BYTE_ENABLE_EN
                    end else begin
                        w_next = S_WR;
`else
                    end else if (size == C_SZ_WORD) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
`endif
                    end
                end
            end
            S_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next = S_WR;
                end
            end
            S_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                misalign = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef EE357_STORE_BYTE_ENABLE_EN
    logic [3:0] r_be;

    assign mem_be = mem_we ? r_be : 4'b0000;

    // Data is replicated across all lanes so the enables alone pick the target bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_be      <= 4'b0000;
        end else if ((r_state == S_IDLE) && start) begin
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            case (size)
                C_SZ_BYTE: begin
                    mem_wdata <= {4{wdata[7:0]}};
                    r_be      <= 4'b0001 << addr[1:0];
                end
                C_SZ_HALF: begin
                    mem_wdata <= {2{wdata[15:0]}};
                    r_be      <= addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    mem_wdata <= wdata;
                    r_be      <= 4'b1111;
                end
            endcase
        end
    end
`else
    logic        r_half;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [31:0] w_merged;

    always_comb begin
        w_merged = mem_rdata;
        if (r_half) begin
            if (r_lane[1]) begin
                w_merged[31:16] = r_wdata;
            end else begin
                w_merged[15:0] = r_wdata;
            end
        end else begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // mem_wdata only changes at capture or on read ack, so it is stable through WR
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_half    <= 1'b0;
            r_lane    <= 2'b00;
            r_wdata   <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            r_half   <= size[0];
            r_lane   <= addr[1:0];
            r_wdata  <= wdata[15:0];
            if (size == C_SZ_WORD) begin
                mem_wdata <= wdata;
            end
        end else if ((r_state == S_RD) && mem_ack) begin
            mem_wdata <= w_merged;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ee357_subword_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ee357_subword_store_unit
// Brief    : Directed self-checking bench with a single-word memory responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_ee357_subword_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy, done, misalign, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
`ifdef EE357_STORE_BYTE_ENABLE_EN
    logic [3:0]  mem_be;
    logic [3:0]  wr_be = 4'b0000;
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int wait_cycles = 0;
    int cnt = 0;
    int n_rd = 0, n_wr = 0, n_done = 0, n_mis = 0, n_req = 0, n_unstable = 0;
    logic [31:0] mem_word = '0, wr_addr = '0, wr_data = '0;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    ee357_subword_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef EE357_STORE_BYTE_ENABLE_EN
        ,
        .mem_be    (mem_be)
`endif
    );

    always #5 clk = ~clk;

    // Memory responder and bus monitor, evaluated away from the active edge
    always @(negedge clk) begin
        if (prev_req && !prev_ack && mem_req &&
            ((mem_addr !== prev_addr) || (mem_we !== prev_we) || (mem_wdata !== prev_wdata)))
            n_unstable++;
        if (done) n_done++;
        if (misalign) n_mis++;
        if (mem_req) n_req++;
        if (rst || !mem_req) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (cnt >= wait_cycles) begin
            mem_ack = 1'b1;
            mem_rdata = mem_word;
            cnt = 0;
            if (mem_we) begin
                n_wr++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
`ifdef EE357_STORE_BYTE_ENABLE_EN
                wr_be = mem_be;
`endif
            end else begin
                n_rd++;
            end
        end else begin
            mem_ack = 1'b0;
            cnt++;
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_we = mem_we;
        prev_addr = mem_addr;
        prev_wdata = mem_wdata;
    end

    task automatic clr();
        @(posedge clk);
        n_rd = 0; n_wr = 0; n_done = 0; n_mis = 0; n_req = 0; n_unstable = 0;
        wr_addr = '0; wr_data = '0;
    endtask

    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        size = sz; addr = a; wdata = d; start = 1'b1;
    endtask

    // lat = negedges after the start cycle until done/misalign is seen
    task automatic run(input bit pulse, output int lat, output bit tmo);
        lat = 0;
        tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (done || misalign) begin
                tmo = 1'b0;
                start = pulse;
                break;
            end
            start = pulse && (lat % 2 == 1);
            if (pulse) begin
                size = 2'b00; addr = 32'h0000_00FC; wdata = 32'hFFFF_FFFF;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if ({busy, done, misalign, mem_req, mem_we} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, misalign, mem_req, mem_we}); end
        tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 00000000", mem_addr); end
        tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 00000000", mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_sb();
        int lat; bit tmo;
        clr(); mem_word = 32'h1122_3344; wait_cycles = 0;
        issue(2'b00, 32'h0000_0102, 32'hDEAD_BEEF);
        run(1'b0, lat, tmo);
        tests++; if (tmo) begin fails++; $display("FAIL sb_timeout got no done exp done"); end
        tests++; if (wr_addr !== 32'h0000_0100) begin fails++; $display("FAIL sb_addr got %h exp 00000100", wr_addr); end
        tests++; if (wr_data !== (BE ? 32'hEFEF_EFEF : 32'h11EF_3344)) begin fails++; $display("FAIL sb_wdata got %h exp %h", wr_data, BE ? 32'hEFEF_EFEF : 32'h11EF_3344); end
        tests++; if (n_rd !== (BE ? 0 : 1)) begin fails++; $display("FAIL sb_reads got %0d exp %0d", n_rd, BE ? 0 : 1); end
        tests++; if ((n_wr !== 1) || (n_done !== 1)) begin fails++; $display("FAIL sb_counts got wr=%0d done=%0d exp 1/1", n_wr, n_done); end
        tests++; if (lat + 1 !== (BE ? 3 : 4)) begin fails++; $display("FAIL sb_latency got %0d exp %0d", lat + 1, BE ? 3 : 4); end
    endtask

    task automatic test_sh();
        int lat; bit tmo;
        logic [31:0] ad [2];
        logic [31:0] ex [2];
        ad[0] = 32'h0000_0012; ex[0] = BE ? 32'h8001_8001 : 32'h8001_BBBB;
        ad[1] = 32'h0000_0010; ex[1] = BE ? 32'h8001_8001 : 32'hAAAA_8001;
        for (int i = 0; i < 2; i++) begin
            clr(); mem_word = 32'hAAAA_BBBB; wait_cycles = 0;
            issue(2'b01, ad[i], 32'h0000_8001);
            run(1'b0, lat, tmo);
            tests++; if (tmo || (n_wr !== 1)) begin fails++; $display("FAIL sh_write%0d got tmo=%0d wr=%0d exp 0/1", i, tmo, n_wr); end
            tests++; if (wr_data !== ex[i]) begin fails++; $display("FAIL sh_wdata%0d got %h exp %h", i, wr_data, ex[i]); end
            tests++; if (wr_addr !== 32'h0000_0010) begin fails++; $display("FAIL sh_addr%0d got %h exp 00000010", i, wr_addr); end
        end
    endtask

    task automatic test_sw();
        int lat; bit tmo;
        clr(); mem_word = 32'hFFFF_0000; wait_cycles = 0;
        issue(2'b10, 32'h0000_0020, 32'h1234_5678);
        run(1'b0, lat, tmo);
        tests++; if (tmo || (n_rd !== 0) || (n_wr !== 1)) begin fails++; $display("FAIL sw_counts got tmo=%0d rd=%0d wr=%0d exp 0/0/1", tmo, n_rd, n_wr); end
        tests++; if ((wr_data !== 32'h1234_5678) || (wr_addr !== 32'h0000_0020)) begin fails++; $display("FAIL sw_write got %h@%h exp 12345678@00000020", wr_data, wr_addr); end
        tests++; if (lat + 1 !== 3) begin fails++; $display("FAIL sw_latency got %0d exp 3", lat + 1); end
    endtask

    task automatic test_misalign();
        int lat; bit tmo;
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        sz[0] = 2'b01; ad[0] = 32'h0000_0003;
        sz[1] = 2'b10; ad[1] = 32'h0000_0002;
        sz[2] = 2'b11; ad[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            clr(); wait_cycles = 0;
            issue(sz[i], ad[i], 32'hCAFE_F00D);
            run(1'b0, lat, tmo);
            repeat (2) @(negedge clk);
            tests++; if (tmo || (lat !== 1) || (n_mis !== 1)) begin fails++; $display("FAIL mis_pulse%0d got tmo=%0d lat=%0d n=%0d exp 0/1/1", i, tmo, lat, n_mis); end
            tests++; if ((n_req !== 0) || (n_done !== 0)) begin fails++; $display("FAIL mis_quiet%0d got req=%0d done=%0d exp 0/0", i, n_req, n_done); end
        end
    endtask

    task automatic test_wait_states();
        int lat; bit tmo;
        clr(); mem_word = 32'h1122_3344; wait_cycles = 5;
        issue(2'b00, 32'h0000_0105, 32'h0000_00A5);
        run(1'b1, lat, tmo);
        repeat (20) @(negedge clk);
        tests++; if (tmo || (n_unstable !== 0)) begin fails++; $display("FAIL ws_stable got tmo=%0d unstable=%0d exp 0/0", tmo, n_unstable); end
        tests++; if ((n_wr !== 1) || (n_done !== 1) || (busy !== 1'b0)) begin fails++; $display("FAIL ws_once got wr=%0d done=%0d busy=%0d exp 1/1/0", n_wr, n_done, busy); end
        tests++; if ((wr_data !== (BE ? 32'hA5A5_A5A5 : 32'h1122_A544)) || (wr_addr !== 32'h0000_0104)) begin fails++; $display("FAIL ws_write got %h@%h exp %h@00000104", wr_data, wr_addr, BE ? 32'hA5A5_A5A5 : 32'h1122_A544); end
        tests++; if (lat + 1 !== (BE ? 8 : 14)) begin fails++; $display("FAIL ws_latency got %0d exp %0d", lat + 1, BE ? 8 : 14); end
        wait_cycles = 0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        clr(); wait_cycles = 1000;
        issue(2'b10, 32'h0000_0040, 32'h55AA_55AA);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_we) begin seen = 1'b1; break; end
        end
        tests++; if (!seen) begin fails++; $display("FAIL rstmid_wr got no write state exp write state"); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if ({busy, done, misalign, mem_req, mem_we} !== 5'b0) begin fails++; $display("FAIL rstmid_ctrl got %b exp 00000", {busy, done, misalign, mem_req, mem_we}); end
        tests++; if ((mem_addr !== 32'h0) || (mem_wdata !== 32'h0)) begin fails++; $display("FAIL rstmid_data got %h/%h exp 0/0", mem_addr, mem_wdata); end
        rst = 1'b0; wait_cycles = 0;
        repeat (5) @(negedge clk);
        tests++; if ((n_wr !== 0) || (n_done !== 0) || (busy !== 1'b0)) begin fails++; $display("FAIL rstmid_abort got wr=%0d done=%0d busy=%0d exp 0/0/0", n_wr, n_done, busy); end
    endtask

    task automatic test_back_to_back();
        bit got;
        clr(); wait_cycles = 0;
        issue(2'b10, 32'h0000_0020, 32'h1234_5678);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin got = 1'b1; break; end
        end
        @(negedge clk);
        size = 2'b10; addr = 32'h0000_0024; wdata = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if (!got || (busy !== 1'b1)) begin fails++; $display("FAIL b2b_accept got done=%0d busy=%0d exp 1/1", got, busy); end
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        @(negedge clk);
        tests++; if (!got || (n_wr !== 2) || (wr_data !== 32'h9ABC_DEF0) || (wr_addr !== 32'h0000_0024)) begin fails++; $display("FAIL b2b_second got done=%0d wr=%0d %h@%h exp 1/2 9abcdef0@00000024", got, n_wr, wr_data, wr_addr); end
    endtask

`ifdef EE357_STORE_BYTE_ENABLE_EN
    task automatic test_byte_enable();
        int lat; bit tmo;
        clr(); wait_cycles = 0;
        issue(2'b00, 32'h0000_0002, 32'hDEAD_BEEF);
        run(1'b0, lat, tmo);
        tests++; if (tmo || (wr_be !== 4'b0100) || (n_rd !== 0)) begin fails++; $display("FAIL be_byte got tmo=%0d be=%b rd=%0d exp 0/0100/0", tmo, wr_be, n_rd); end
        tests++; if (wr_data !== 32'hEFEF_EFEF) begin fails++; $display("FAIL be_wdata got %h exp efefefef", wr_data); end
        tests++; if (mem_be !== 4'b0000) begin fails++; $display("FAIL be_idle got %b exp 0000", mem_be); end
        clr();
        issue(2'b01, 32'h0000_0002, 32'h0000_1234);
        run(1'b0, lat, tmo);
        tests++; if (tmo || (wr_be !== 4'b1100) || (wr_data !== 32'h1234_1234)) begin fails++; $display("FAIL be_half got be=%b %h exp 1100 12341234", wr_be, wr_data); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_sw();
        test_misalign();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
`ifdef EE357_STORE_BYTE_ENABLE_EN
        test_byte_enable();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
